// File: rtl/rob_pkg.sv
// Shared types and constants for the reorder buffer.
//   robn_t          : entry index (ROB_SIZE entries)
//   rob_ptr_t       : index plus wrap bit, used for head/tail
//   rob_entry_t     : one in-flight instruction
//   fu_rob_packet_t : completion broadcast from a functional unit (CDB lane)
//   rob_ct_packet_t : one retire slot (valid + entry)
package rob_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned ROB_SIZE = 32;  // power of 2, >= 2 * dispatch width
  localparam int unsigned ROBN_W   = $clog2(ROB_SIZE);
  localparam int unsigned PRN_W    = 6;
  localparam int unsigned ARN_W    = 5;

  typedef logic [ROBN_W-1:0] robn_t;
  typedef logic [ROBN_W:0]   rob_ptr_t;

  typedef struct packed {
    logic            executed;
    logic            success;
    logic            is_store;
    logic            cond_branch;
    logic            uncond_branch;
    logic            predict_taken;
    logic [XLEN-1:0] predict_target;
    logic            resolve_taken;
    logic [XLEN-1:0] resolve_target;
    logic [PRN_W-1:0] dest_prn;
    logic [ARN_W-1:0] dest_arn;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc;
    logic            halt;
    logic            illegal;
    logic            csr_op;
  } rob_entry_t;

  typedef struct packed {
    logic            executed;
    robn_t           robn;
    logic            branch_taken;
    logic [XLEN-1:0] target_addr;
  } fu_rob_packet_t;

  typedef struct packed {
    logic       valid;
    rob_entry_t entry;
  } rob_ct_packet_t;

  localparam rob_entry_t ENTRY_RESET = '{success: 1'b1, default: '0};

  function automatic logic is_mispredict(input rob_entry_t e);
    return (e.cond_branch | e.uncond_branch) & ~e.success;
  endfunction

endpackage

// File: rtl/rob_commit_select.sv
// Retire-slot selection over the CmtW oldest entries (pure combinational).
//   entry_i/alloc_i : window of entries starting at head, and whether each is allocated
//   enable_i        : low once the machine has halted
//   valid_o         : packed-low retire valids
//   retire_cnt_o    : number of entries retiring
//   squash_o        : a mispredicted branch retires in slot squash_slot_o
//   halt_o          : a halt/illegal entry retires
module rob_commit_select
  import rob_pkg::*;
#(
  parameter int unsigned CmtW = 2,
  localparam int unsigned CntW = $clog2(CmtW + 1),
  localparam int unsigned IdxW = (CmtW > 1) ? $clog2(CmtW) : 1
) (
  input  rob_entry_t [CmtW-1:0] entry_i,
  input  logic [CmtW-1:0]       alloc_i,
  input  logic                  enable_i,
  output logic [CmtW-1:0]       valid_o,
  output logic [CntW-1:0]       retire_cnt_o,
  output logic                  squash_o,
  output logic [IdxW-1:0]       squash_slot_o,
  output logic                  halt_o
);

  always_comb begin
    int unsigned n;
    logic        stop;
    valid_o       = '0;
    squash_o      = 1'b0;
    squash_slot_o = '0;
    halt_o        = 1'b0;
    stop          = !enable_i;
    n             = 0;
    for (int k = 0; k < CmtW; k++) begin
      if (!stop && alloc_i[k] && entry_i[k].executed) begin
        valid_o[k] = 1'b1;
        n++;
        // The entry that ends the group still retires; everything after it waits.
        if (is_mispredict(entry_i[k])) begin
          squash_o      = 1'b1;
          squash_slot_o = IdxW'(k);
          stop          = 1'b1;
        end
        if (entry_i[k].halt || entry_i[k].illegal) begin
          halt_o = 1'b1;
          stop   = 1'b1;
        end
      end else begin
        stop = 1'b1;
      end
    end
    retire_cnt_o = CntW'(n);
  end

endmodule

// File: rtl/rob_multiport.sv
// Reorder buffer: circular FIFO of in-flight instructions between dispatch and retire.
//   clk_i, rst_ni    : clock, asynchronous active-low reset
//   disp_valid_i     : packed-low dispatch valids; disp_entry_i slot 0 is oldest
//   disp_ready_o     : whole group accepted this cycle (no partial acceptance)
//   tail_robn_o      : index each dispatch slot will occupy
//   cdb_packet_i     : completion lanes
//   ct_valid_o       : packed-low retire valids; ct_entry_o slot 0 is oldest
//   squash_o         : mispredict retires now; squash_pc_o is the redirect target
//   halted_o         : sticky after a halt/illegal retires
//   free_slots_o     : ROB_SIZE - occupancy
module rob_multiport
  import rob_pkg::*;
#(
  parameter int unsigned DispW = 2,
  parameter int unsigned CmtW  = 2,
  parameter int unsigned CdbW  = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [DispW-1:0]          disp_valid_i,
  input  rob_entry_t [DispW-1:0]    disp_entry_i,
  output logic                      disp_ready_o,
  output robn_t [DispW-1:0]         tail_robn_o,
  input  fu_rob_packet_t [CdbW-1:0] cdb_packet_i,
  output logic [CmtW-1:0]           ct_valid_o,
  output rob_entry_t [CmtW-1:0]     ct_entry_o,
  output logic                      squash_o,
  output logic [XLEN-1:0]           squash_pc_o,
  output logic                      halted_o,
  output logic [ROBN_W:0]           free_slots_o
);

  localparam int unsigned CntW = $clog2(CmtW + 1);
  localparam int unsigned IdxW = (CmtW > 1) ? $clog2(CmtW) : 1;

  rob_entry_t entries_q [ROB_SIZE];
  rob_entry_t entries_d [ROB_SIZE];
  rob_ptr_t   head_q, head_d, tail_q, tail_d;
  logic       halted_q, halted_d;

  rob_ptr_t   count, free_slots;
  robn_t      head_idx, tail_idx;

  rob_entry_t [CmtW-1:0]     win_entry;
  logic [CmtW-1:0]           win_alloc;
  logic [CmtW-1:0]           sel_valid;
  logic [CntW-1:0]           sel_cnt;
  logic                      sel_squash, sel_halt;
  logic [IdxW-1:0]           sel_slot;
  rob_entry_t                squash_entry;
  rob_ct_packet_t [CmtW-1:0] ct_pkt;

  assign head_idx   = head_q[ROBN_W-1:0];
  assign tail_idx   = tail_q[ROBN_W-1:0];
  // Wrap bit makes the modular difference exact for 0..ROB_SIZE.
  assign count      = tail_q - head_q;
  assign free_slots = rob_ptr_t'(ROB_SIZE) - count;

  assign free_slots_o = free_slots;
  assign halted_o     = halted_q;
  assign disp_ready_o = (free_slots >= rob_ptr_t'(DispW)) && !halted_q && !sel_squash;

  always_comb begin
    for (int i = 0; i < DispW; i++) begin
      tail_robn_o[i] = robn_t'(tail_idx + robn_t'(i));
    end
    for (int k = 0; k < CmtW; k++) begin
      win_entry[k] = entries_q[robn_t'(head_idx + robn_t'(k))];
      win_alloc[k] = rob_ptr_t'(k) < count;
    end
  end

  rob_commit_select #(
    .CmtW (CmtW)
  ) u_commit_select (
    .entry_i       (win_entry),
    .alloc_i       (win_alloc),
    .enable_i      (!halted_q),
    .valid_o       (sel_valid),
    .retire_cnt_o  (sel_cnt),
    .squash_o      (sel_squash),
    .squash_slot_o (sel_slot),
    .halt_o        (sel_halt)
  );

  always_comb begin
    for (int k = 0; k < CmtW; k++) begin
      ct_pkt[k].valid = sel_valid[k];
      ct_pkt[k].entry = win_entry[k];
      ct_valid_o[k]   = ct_pkt[k].valid;
      ct_entry_o[k]   = ct_pkt[k].entry;
    end
  end

  assign squash_entry = win_entry[sel_slot];
  assign squash_o     = sel_squash;
  assign squash_pc_o  = squash_entry.resolve_taken ? squash_entry.resolve_target
                                                   : squash_entry.pc + XLEN'(4);

  always_comb begin
    robn_t       off;
    robn_t       r;
    int unsigned n;
    entries_d = entries_q;
    head_d    = head_q + rob_ptr_t'(sel_cnt);
    tail_d    = tail_q;
    halted_d  = halted_q | sel_halt;
    off       = '0;
    r         = '0;
    n         = 0;
    if (sel_squash) begin
      // Everything younger than the branch is dropped, including this cycle's writes.
      head_d = head_q + rob_ptr_t'(sel_slot) + rob_ptr_t'(1);
      tail_d = head_d;
    end else begin
      for (int l = 0; l < CdbW; l++) begin
        r   = cdb_packet_i[l].robn;
        off = r - head_idx;
        if (cdb_packet_i[l].executed && (rob_ptr_t'(off) < count)) begin
          entries_d[r].executed       = 1'b1;
          entries_d[r].resolve_taken  = cdb_packet_i[l].branch_taken;
          entries_d[r].resolve_target = cdb_packet_i[l].target_addr;
          if (entries_d[r].cond_branch || entries_d[r].uncond_branch) begin
            entries_d[r].success =
              (cdb_packet_i[l].branch_taken == entries_d[r].predict_taken) &&
              (cdb_packet_i[l].target_addr == entries_d[r].predict_target);
          end
        end
      end
      if (disp_ready_o) begin
        for (int i = 0; i < DispW; i++) begin
          if (disp_valid_i[i]) begin
            r                     = robn_t'(tail_idx + robn_t'(i));
            entries_d[r]          = disp_entry_i[i];
            entries_d[r].executed = 1'b0;
            entries_d[r].success  = 1'b1;
            n++;
          end
        end
        tail_d = tail_q + rob_ptr_t'(n);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q   <= '0;
      tail_q   <= '0;
      halted_q <= 1'b0;
      for (int unsigned i = 0; i < ROB_SIZE; i++) begin
        entries_q[i] <= ENTRY_RESET;
      end
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      halted_q  <= halted_d;
      entries_q <= entries_d;
    end
  end

  for (genvar a = 0; a < CdbW; a++) begin : g_cdb_a
    for (genvar b = a + 1; b < CdbW; b++) begin : g_cdb_b
      // Two lanes must never complete the same entry in one cycle.
      assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(cdb_packet_i[a].executed && cdb_packet_i[b].executed &&
          (cdb_packet_i[a].robn == cdb_packet_i[b].robn)));
    end
  end

endmodule
